// File: rtl/relu_queue_sequencer_pkg.sv
// Shared sizing defaults and FSM encoding for the ReLU queue sequencer.
// Build option: RELU_ZERO_SKIP_EN (zero-valued nodes bypass the MAC).
`ifndef RELU_NODES
`define RELU_NODES 4
`endif
`ifndef RELU_INDEX_WIDTH
`define RELU_INDEX_WIDTH 2
`endif
`ifndef LAYER_2_IN_BIT_WIDTH
`define LAYER_2_IN_BIT_WIDTH 8
`endif

package relu_queue_sequencer_pkg;

  localparam int DEF_RELU_NODES = `RELU_NODES;
  localparam int DEF_INDEX_W    = `RELU_INDEX_WIDTH;
  localparam int DEF_VALUE_W    = `LAYER_2_IN_BIT_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DEQ     = 3'd2,
    CAPTURE = 3'd3,
    FETCH   = 3'd4,
    WAIT_W  = 3'd5,
    ISSUE   = 3'd6,
    DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/relu_queue_sequencer.sv
// Drains queued layer-1 ReLU outputs, fetches weights, feeds the MAC.
// Build option: RELU_ZERO_SKIP_EN (zero-valued nodes bypass the MAC).
`ifndef RELU_NODES
`define RELU_NODES 4
`endif
`ifndef RELU_INDEX_WIDTH
`define RELU_INDEX_WIDTH 2
`endif
`ifndef LAYER_2_IN_BIT_WIDTH
`define LAYER_2_IN_BIT_WIDTH 8
`endif

module relu_queue_sequencer
  import relu_queue_sequencer_pkg::*;
#(
  parameter int RELU_NODES           = `RELU_NODES,
  parameter int RELU_INDEX_WIDTH     = `RELU_INDEX_WIDTH,
  parameter int LAYER_2_IN_BIT_WIDTH = `LAYER_2_IN_BIT_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            queue_write_enable,
  output logic                            queue_dequeue,
  output logic                            queue_reset,
  input  logic [RELU_INDEX_WIDTH-1:0]     queue_index_in,
  input  logic [LAYER_2_IN_BIT_WIDTH-1:0] queue_value_in,
  input  logic                            queue_empty,
  output logic                            weight_rd,
  output logic [RELU_INDEX_WIDTH-1:0]     weight_addr,
  input  logic                            weight_valid,
  output logic                            mac_valid,
  input  logic                            mac_ready,
  output logic [LAYER_2_IN_BIT_WIDTH-1:0] mac_value,
  output logic [RELU_INDEX_WIDTH-1:0]     mac_index,
  output logic                            mac_last,
  output logic                            busy,
  output logic                            done,
  output logic [RELU_INDEX_WIDTH:0]       mac_count
);

  localparam int CW = RELU_INDEX_WIDTH + 1;

  state_t state;
  state_t state_n;

  logic [RELU_INDEX_WIDTH-1:0]     idx_q;
  logic [RELU_INDEX_WIDTH-1:0]     addr_q;
  logic [LAYER_2_IN_BIT_WIDTH-1:0] val_q;
  logic [CW-1:0]                   cnt_q;
  logic                            rst_hold_q;
  logic                            qrst_q;
  logic                            xfer;
  logic                            skip;

  assign xfer = (state == ISSUE) && mac_ready;

`ifdef RELU_ZERO_SKIP_EN
  assign skip = (queue_value_in == '0);
`else
  assign skip = 1'b0;
`endif

  assign busy        = (state != IDLE);
  assign mac_value   = val_q;
  assign mac_index   = idx_q;
  assign mac_last    = (idx_q == RELU_INDEX_WIDTH'(RELU_NODES - 1));
  assign mac_count   = cnt_q;
  assign queue_reset = qrst_q;
  // Address follows the index in FETCH, then holds until the next FETCH.
  assign weight_addr = (state == FETCH) ? idx_q : addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_n            = state;
    queue_write_enable = 1'b0;
    queue_dequeue      = 1'b0;
    weight_rd          = 1'b0;
    mac_valid          = 1'b0;
    done               = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: begin
        queue_write_enable = 1'b1;
        state_n            = DEQ;
      end
      DEQ: begin
        queue_dequeue = 1'b1;
        state_n       = CAPTURE;
      end
      CAPTURE: begin
        if (skip) state_n = queue_empty ? DONE : DEQ;
        else      state_n = FETCH;
      end
      FETCH: begin
        weight_rd = 1'b1;
        state_n   = WAIT_W;
      end
      WAIT_W: if (weight_valid) state_n = ISSUE;
      ISSUE: begin
        mac_valid = 1'b1;
        if (mac_ready) state_n = queue_empty ? DONE : DEQ;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Node capture, weight address hold, saturating transfer count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q  <= '0;
      val_q  <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state == CAPTURE) begin
        idx_q <= queue_index_in;
        val_q <= queue_value_in;
      end
      if (state == FETCH) addr_q <= idx_q;
      if (state == LOAD)
        cnt_q <= '0;
      else if (xfer && (cnt_q < CW'(RELU_NODES)))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Queue reset covers the reset window plus one cycle after release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_hold_q <= 1'b1;
      qrst_q     <= 1'b1;
    end else begin
      rst_hold_q <= 1'b0;
      qrst_q     <= rst_hold_q;
    end
  end

endmodule

// File: tb/tb_relu_queue_sequencer.sv
// Scoreboard bench: queue/weight/MAC models plus randomized passes.
// Build option: RELU_ZERO_SKIP_EN (zero-valued nodes bypass the MAC).
module tb_relu_queue_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int VW = 8;

`ifdef RELU_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int idx;
    int val;
  } node_t;

  typedef struct {
    int idx;
    int val;
    int last;
  } xfer_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          queue_write_enable;
  logic          queue_dequeue;
  logic          queue_reset;
  logic [IW-1:0] queue_index_in;
  logic [VW-1:0] queue_value_in;
  logic          queue_empty;
  logic          weight_rd;
  logic [IW-1:0] weight_addr;
  logic          weight_valid;
  logic          mac_valid;
  logic          mac_ready;
  logic [VW-1:0] mac_value;
  logic [IW-1:0] mac_index;
  logic          mac_last;
  logic          busy;
  logic          done;
  logic [IW:0]   mac_count;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int wv_delay = 1;

  node_t pend[$];
  node_t qmodel[$];
  xfer_t exp_xfer[$];
  int    exp_fetch[$];
  int    exp_done[$];

  relu_queue_sequencer #(
    .RELU_NODES(N),
    .RELU_INDEX_WIDTH(IW),
    .LAYER_2_IN_BIT_WIDTH(VW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .queue_write_enable(queue_write_enable),
    .queue_dequeue(queue_dequeue),
    .queue_reset(queue_reset),
    .queue_index_in(queue_index_in),
    .queue_value_in(queue_value_in),
    .queue_empty(queue_empty),
    .weight_rd(weight_rd),
    .weight_addr(weight_addr),
    .weight_valid(weight_valid),
    .mac_valid(mac_valid),
    .mac_ready(mac_ready),
    .mac_value(mac_value),
    .mac_index(mac_index),
    .mac_last(mac_last),
    .busy(busy),
    .done(done),
    .mac_count(mac_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Node queue model: load on write enable, pop on dequeue.
  initial begin
    queue_index_in = '0;
    queue_value_in = '0;
    queue_empty    = 1'b1;
    forever begin
      @(negedge clk);
      if (queue_reset === 1'b1) qmodel.delete();
      if (queue_write_enable === 1'b1) begin
        qmodel = pend;
        pend.delete();
      end
      if (queue_dequeue === 1'b1 && qmodel.size() > 0) begin
        node_t n;
        n = qmodel.pop_front();
        queue_index_in = IW'(n.idx);
        queue_value_in = VW'(n.val);
      end
      queue_empty = (qmodel.size() == 0);
    end
  end

  // Weight store model: valid arrives wv_delay cycles after a read.
  initial begin
    int cnt;
    cnt = 0;
    weight_valid = 1'b0;
    forever begin
      @(negedge clk);
      weight_valid = 1'b0;
      if (reset !== 1'b1) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) weight_valid = 1'b1;
      end
      if (weight_rd === 1'b1 && reset === 1'b1)
        cnt = (wv_delay > 0) ? wv_delay : int'($urandom_range(1, 4));
    end
  end

  // MAC sink: always ready, random, or a 6-cycle stall on index 2.
  initial begin
    int stall_n;
    stall_n = 0;
    mac_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_mode == 0) begin
        stall_n = 0;
        mac_ready = 1'b1;
      end else if (ready_mode == 1) begin
        stall_n = 0;
        mac_ready = ($urandom_range(0, 3) != 0);
      end else if (mac_valid === 1'b1 && mac_index == 2 && stall_n < 6) begin
        stall_n++;
        mac_ready = 1'b0;
      end else begin
        mac_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something.
  initial begin
    int hold;
    bit prev_stall;
    bit prev_deq;
    int pv;
    int pi;
    xfer_t e;
    hold = 0;
    prev_stall = 0;
    prev_deq = 0;
    pv = 0;
    pi = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        hold = 0;
        prev_stall = 0;
        prev_deq = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", int'(mac_valid), 1);
          chk("hold_value", int'(mac_value), pv);
          chk("hold_index", int'(mac_index), pi);
        end
        if (queue_dequeue === 1'b1) chk("deq_gap", int'(prev_deq), 0);
        prev_deq = (queue_dequeue === 1'b1);
        if (weight_rd === 1'b1) begin
          if (exp_fetch.size() == 0) fail("fetch_unexpected", int'(weight_addr), -1);
          else chk("fetch_addr", int'(weight_addr), exp_fetch.pop_front());
        end
        if (mac_valid === 1'b1) hold++;
        if (mac_valid === 1'b1 && mac_ready === 1'b1) begin
          if (exp_xfer.size() == 0) begin
            fail("xfer_unexpected", int'(mac_index), -1);
          end else begin
            e = exp_xfer.pop_front();
            chk("xfer_index", int'(mac_index), e.idx);
            chk("xfer_value", int'(mac_value), e.val);
            chk("xfer_last", int'(mac_last), e.last);
          end
          if (ready_mode == 2 && mac_index == 2) chk("stall_len", hold, 7);
          hold = 0;
        end
        prev_stall = (mac_valid === 1'b1) && (mac_ready !== 1'b1);
        pv = int'(mac_value);
        pi = int'(mac_index);
        if (done === 1'b1) begin
          done_cnt++;
          if (exp_done.size() == 0) begin
            fail("done_unexpected", int'(mac_count), -1);
          end else begin
            chk("done_count", int'(mac_count), exp_done.pop_front());
            chk("done_drained", exp_xfer.size(), 0);
          end
        end
      end
    end
  end

  task automatic run_pass(input int vals[N], input int rmode,
                          input int wvd, input bit restart, input bit lat);
    int n_exp;
    int cyc;
    int first;
    int d0;
    bit pulsed;
    n_exp = 0;
    first = -1;
    pulsed = 0;
    pend.delete();
    for (int i = 0; i < N; i++) begin
      node_t n;
      n.idx = i;
      n.val = vals[i];
      pend.push_back(n);
      if (!(SKIP && vals[i] == 0)) begin
        xfer_t x;
        x.idx = i;
        x.val = vals[i];
        x.last = (i == N - 1) ? 1 : 0;
        exp_xfer.push_back(x);
        exp_fetch.push_back(i);
        n_exp++;
      end
    end
    exp_done.push_back(n_exp);
    ready_mode = rmode;
    wv_delay = wvd;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_cnt == d0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (first < 0 && mac_valid === 1'b1) first = cyc;
      if (restart && !pulsed && mac_valid === 1'b1) begin
        start = 1'b1;
        pulsed = 1;
      end
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      fail("pass_timeout", cyc, 400);
      exp_xfer.delete();
      exp_fetch.delete();
      exp_done.delete();
    end
    if (lat) chk("latency", first, 5 + wvd);
    repeat (8) @(negedge clk);
    #2;
    chk("done_once", done_cnt - d0, 1);
    chk("idle_after", int'(busy), 0);
    chk("count_hold", int'(mac_count), n_exp);
  endtask

  initial begin
    int base[N];
    int rv[N];
    int d0;
    bit found;
    reset = 1'b0;
    start = 1'b0;
    base[0] = 5;
    base[1] = 0;
    base[2] = 7;
    base[3] = 3;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_queue_reset", int'(queue_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobes",
        int'({done, mac_valid, weight_rd, queue_write_enable, queue_dequeue}), 0);
    chk("rst_mac_count", int'(mac_count), 0);
    chk("rst_mac_out", int'({mac_value, mac_index, mac_last}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("qrst_after_release", int'(queue_reset), 1);
    @(negedge clk);
    #2;
    chk("qrst_cleared", int'(queue_reset), 0);

    run_pass(base, 0, 1, 1'b0, 1'b1);
    run_pass(base, 2, 1, 1'b0, 1'b0);
    run_pass(base, 1, 0, 1'b1, 1'b0);

    rv[0] = 5;
    rv[1] = 9;
    rv[2] = 7;
    rv[3] = 3;
    pend.delete();
    for (int i = 0; i < N; i++) begin
      node_t n;
      n.idx = i;
      n.val = rv[i];
      pend.push_back(n);
    end
    begin
      xfer_t x;
      x.idx = 0;
      x.val = 5;
      x.last = 0;
      exp_xfer.push_back(x);
    end
    exp_fetch.push_back(0);
    exp_fetch.push_back(1);
    ready_mode = 0;
    wv_delay = 4;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (weight_rd === 1'b1 && weight_addr == 1) found = 1;
    end
    chk("reach_wait_w", int'(found), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_queue_reset", int'(queue_reset), 1);
    chk("midrst_strobes", int'({done, mac_valid, weight_rd}), 0);
    chk("midrst_drained", exp_xfer.size() + exp_fetch.size(), 0);
    exp_xfer.delete();
    exp_fetch.delete();
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_valid", int'(mac_valid), 0);

    run_pass(rv, 0, 2, 1'b0, 1'b1);

    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < N; i++)
        rv[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      run_pass(rv, 1, 0, 1'b0, 1'b0);
    end

    chk("leftover_expect", exp_xfer.size() + exp_fetch.size() + exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
